mem_port_ctrl: RTL and testbench
================================

# mem_port_ctrl

Parametrised byte-serial memory controller that arbitrates `NPORT` request channels onto the single 8-bit RAM/IO bus of the RISC-V core. It sits between the core's instruction/data front-ends (ICache, LSB, future prefetchers) and the external `mem_*` pins. It serialises 1/2/4-byte loads and stores and assembles little-endian results. It adds fair round-robin arbitration, per-port flush abort and UART back-pressure handling.

## Interface
- `NPORT`, 2: number of request ports (2..8); port index 0 is lowest.
- `FLUSH_MASK`, 2'b11: bit p=1 means reads from port p are aborted by `flush_in`.
- `IO_BIT_HI`, 17: I/O space is selected when addr[IO_BIT_HI:IO_BIT_HI-1]==2'b11.

Ports:
- `clk_in` in 1: clock.
- `rst_in` in 1: reset; one clock; reset is asynchronous and active-high.
- `rdy_in` in 1: pause when low.
- `flush_in` in 1: misprediction clear from ROB.
- `io_buffer_full` in 1: UART TX buffer full.
- `mem_din` in 8: read byte, valid one cycle after address.
- `mem_dout` out 8: write byte.
- `mem_a` out 32: byte address.
- `mem_wr` out 1: 1 = write.
- `req_valid` in NPORT: request level per port.
- `req_write` in NPORT: 1 = store.
- `req_size` in 2*NPORT: 00 byte, 01 half, 10 word; 11 treated as word.
- `req_signed` in NPORT: sign-extend load result.
- `req_addr` in 32*NPORT: start address, port p at [32p+31:32p].
- `req_wdata` in 32*NPORT: store data, little-endian.
- `resp_valid` out NPORT: one-cycle completion pulse, one-hot.
- `resp_data` out 32: load result; shared by all ports, qualified by `resp_valid`.
- `busy` out 1: FSM not in IDLE.

## Operation
- FSM states:
  - IDLE: arbitrates.
  - ACCESS: one byte per cycle, counter k = 0..n-1, where n = 1/2/4.
  - DONE: `resp_valid` high for one cycle.
- Transitions:
  - IDLE→ACCESS on any eligible request.
  - ACCESS→DONE after the last byte is issued (write) or captured (read).
  - DONE→IDLE unconditionally.
- Arbitration:
  - Round-robin; pointer resets to 0.
  - Search order is pointer, pointer+1, … mod NPORT.
  - After granting port p, pointer = (p+1) mod NPORT.
  - Request fields are latched at grant; later changes are ignored.
- Byte k address = latched addr + k, 32-bit wrap. Misaligned accesses are legal.
- Reads:
  - Byte k captured into result bits [8k+7:8k] from `mem_din` the cycle after its address.
  - Upper bits are zero-extended, or sign-extended from bit 8n-1 when `req_signed`.
- Writes:
  - `mem_dout` = wdata[8k+7:8k], with `mem_wr`=1.
  - If the byte address is in I/O space and `io_buffer_full`=1, the byte is held with `mem_wr`=0 and k does not advance until full clears.
- Outside ACCESS: `mem_a`=0, `mem_wr`=0, `mem_dout`=0.
- Requester protocol:
  - Hold `req_valid` until `resp_valid[p]`.
  - Deassert by the next edge, or the request is taken as a new one.
- Flush:
  - In a `flush_in` cycle, ports with FLUSH_MASK=1 are not granted.
  - An in-flight read from such a port returns to IDLE next edge with no `resp_valid`.
  - Writes and reads from unmasked ports always complete.
  - Flush during DONE suppresses the pulse only for masked reads.
- `rdy_in`=0: all state, pointer and counters hold; `mem_wr` forced 0.

## Timing
- Reset values: `mem_a`=0, `mem_dout`=0, `mem_wr`=0, `resp_valid`=0, `resp_data`=0, `busy`=0, pointer=0, state IDLE.
- Reset mid-access: bus returns to idle immediately; no response is issued.
- Request sampled in IDLE at cycle T → byte k address driven at cycle T+1+k.
- Read, n bytes: data captured at T+2..T+1+n; `resp_valid`/`resp_data` at T+2+n.
  - Latencies: lb 3, lh 4, lw 6 cycles after T.
- Write, n bytes: `mem_wr` at T+1..T+n; `resp_valid` at T+1+n. Each I/O-full stall cycle adds one.
- Back-to-back: the next grant is sampled in the IDLE cycle after DONE, so there is a minimum 1-cycle bus gap.

## Test plan
- Port 1 lw 0x100, RAM bytes 11 22 33 44 → addresses 0x100..0x103 at T+1..T+4; `resp_valid`=2'b10 with `resp_data`=0x44332211 at T+6.
- Ports 0 and 1 request continuously from reset → grants alternate 0,1,0,1; no port waits more than one other transaction.
- lb signed at 0x200 holding 0x80 → 0xFFFFFF80; lhu at 0x1FF (bytes 0xFE,0xCA) → 0x0000CAFE.
- sw 0xDEADBEEF to 0x30000 with `io_buffer_full`=1 for 3 cycles at byte 1 → bytes EF,BE,AD,DE written once each; `resp_valid` at T+8.
- Port 0 lw, `flush_in` at T+3 → no `resp_valid`, `busy`=0 at T+4; concurrent port-1 sw with FLUSH_MASK=2'b01 still completes.
- `rst_in` pulsed mid-sw at k=2 → `mem_wr`=0 and all outputs zero while reset is asserted; first post-reset grant goes to port 0.

Source files
------------

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: round-robin arbitration of NPORT load/store channels onto the core's
// 8-bit RAM/IO bus; each access is serialised one byte per cycle, little-endian.

package mem_port_ctrl_pkg;
  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;
endpackage

module mem_port_ctrl_lane
  import mem_port_ctrl_pkg::*;
#(
  parameter logic MASKED = 1'b1
) (
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush_in,
  output logic        eligible,
  output mreq_t       req
);
  assign eligible = req_valid & ~(flush_in & MASKED);
  assign req      = '{write: req_write, size: req_size, sgn: req_signed,
                      addr: req_addr, wdata: req_wdata};
endmodule

module mem_port_ctrl
  import mem_port_ctrl_pkg::*;
#(
  parameter int               NPORT      = 2,
  parameter logic [NPORT-1:0] FLUSH_MASK = {NPORT{1'b1}},
  parameter int               IO_BIT_HI  = 17
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 io_buffer_full,
  input  logic [7:0]           mem_din,
  output logic [7:0]           mem_dout,
  output logic [31:0]          mem_a,
  output logic                 mem_wr,
  input  logic [NPORT-1:0]     req_valid,
  input  logic [NPORT-1:0]     req_write,
  input  logic [2*NPORT-1:0]   req_size,
  input  logic [NPORT-1:0]     req_signed,
  input  logic [32*NPORT-1:0]  req_addr,
  input  logic [32*NPORT-1:0]  req_wdata,
  output logic [NPORT-1:0]     resp_valid,
  output logic [31:0]          resp_data,
  output logic                 busy
);
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        state;
  logic [PW-1:0]     ptr, gnt, pick, ptr_nxt;
  logic              found;
  logic [CW-1:0]     cand;
  logic [NPORT-1:0]  elig;
  mreq_t [NPORT-1:0] req_s;
  mreq_t             req_q;
  logic [2:0]        k, nbytes;
  logic              cap_vld;
  logic [1:0]        cap_idx;
  logic [31:0]       rbuf, byte_addr;
  logic [7:0]        wbyte;
  logic              issuing, is_io, stall, advance, abort;

  for (genvar p = 0; p < NPORT; p++) begin : g_lane
    mem_port_ctrl_lane #(.MASKED(FLUSH_MASK[p])) u_lane (
      .req_valid  (req_valid[p]),
      .req_write  (req_write[p]),
      .req_size   (req_size[2*p +: 2]),
      .req_signed (req_signed[p]),
      .req_addr   (req_addr[32*p +: 32]),
      .req_wdata  (req_wdata[32*p +: 32]),
      .flush_in   (flush_in),
      .eligible   (elig[p]),
      .req        (req_s[p])
    );
  end

  // First eligible port searching upward from the pointer, wrapping at NPORT.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NPORT; i++) begin
      cand = CW'(ptr) + CW'(i);
      if (cand >= CW'(NPORT)) cand = cand - CW'(NPORT);
      if (!found && elig[cand[PW-1:0]]) begin
        found = 1'b1;
        pick  = cand[PW-1:0];
      end
    end
  end

  assign ptr_nxt = (pick == PW'(NPORT - 1)) ? '0 : pick + PW'(1);

  always_comb begin
    case (req_q.size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  assign byte_addr = req_q.addr + {29'd0, k};
  assign wbyte     = req_q.wdata[{k[1:0], 3'b000} +: 8];
  assign is_io     = (byte_addr[IO_BIT_HI -: 2] == 2'b11);
  assign issuing   = (state == S_ACCESS) && (k < nbytes);
  assign stall     = req_q.write && is_io && io_buffer_full;
  assign advance   = issuing && rdy_in && !stall;
  // Abort ignores rdy_in: a flush lost during a pause would otherwise leak a stale load.
  assign abort     = flush_in && !req_q.write && FLUSH_MASK[gnt] && (state != S_IDLE);

  assign mem_a    = issuing ? byte_addr : 32'd0;
  assign mem_dout = (issuing && req_q.write) ? wbyte : 8'd0;
  assign mem_wr   = issuing && req_q.write && rdy_in && !stall;
  assign busy     = (state != S_IDLE);

  always_comb begin
    resp_valid = '0;
    if (state == S_DONE && rdy_in && !abort) resp_valid[gnt] = 1'b1;
  end

  always_comb begin
    case (req_q.size)
      2'b00:   resp_data = {{24{req_q.sgn & rbuf[7]}}, rbuf[7:0]};
      2'b01:   resp_data = {{16{req_q.sgn & rbuf[15]}}, rbuf[15:0]};
      default: resp_data = rbuf;
    endcase
  end

  // Read data arrives the cycle after its address, so capture trails issue by one
  // cycle; it completes even across a pause since the bus already returned it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= S_IDLE;
      ptr     <= '0;
      gnt     <= '0;
      req_q   <= '0;
      k       <= 3'd0;
      cap_vld <= 1'b0;
      cap_idx <= 2'd0;
      rbuf    <= 32'd0;
    end else begin
      if (cap_vld) rbuf[{cap_idx, 3'b000} +: 8] <= mem_din;
      cap_vld <= advance && !req_q.write;
      cap_idx <= k[1:0];
      if (abort) begin
        state   <= S_IDLE;
        cap_vld <= 1'b0;
      end else if (rdy_in) begin
        case (state)
          S_IDLE: begin
            if (found) begin
              state <= S_ACCESS;
              gnt   <= pick;
              ptr   <= ptr_nxt;
              req_q <= req_s[pick];
              k     <= 3'd0;
              rbuf  <= 32'd0;
            end
          end
          S_ACCESS: begin
            if (advance) begin
              k <= k + 3'd1;
              if (req_q.write && (k == nbytes - 3'd1)) state <= S_DONE;
            end else if (!req_q.write && (k == nbytes)) begin
              state <= S_DONE;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: byte-serial RAM model, per-cycle timing checks.
`timescale 1ns/1ps
module tb_mem_port_ctrl;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [1:0]  req_valid, req_write, req_signed;
  logic [3:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  resp_valid;
  logic [31:0] resp_data;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  ram [0:4095];
  logic [39:0] wlog [$];

  mem_port_ctrl #(.NPORT(2), .FLUSH_MASK(2'b01), .IO_BIT_HI(17)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) mem_din <= ram[mem_a[11:0]];
  always @(posedge clk_in) if (mem_wr) wlog.push_back({mem_a, mem_dout});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_in); #1;
  endtask

  task automatic smp();
    @(negedge clk_in);
  endtask

  task automatic set_req(input int p, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    req_write[p] = wr;
    req_size[2*p +: 2] = sz;
    req_signed[p] = sg;
    req_addr[32*p +: 32] = a;
    req_wdata[32*p +: 32] = wd;
    req_valid[p] = 1'b1;
  endtask

  // Issue a load at cycle T; check byte addresses, latency and final data.
  task automatic do_rd(input int p, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input int lat, input logic [31:0] exp);
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    nxt(); set_req(p, 1'b0, sz, sg, a, 32'd0); smp();
    chk($sformatf("rd_idle a=%h", a), {31'd0, busy}, 32'd0);
    for (int i = 1; i < lat; i++) begin
      nxt(); smp();
      if (i <= n) chk($sformatf("rd_addr a=%h k%0d", a, i - 1), mem_a, a + 32'(i - 1));
      chk($sformatf("rd_early a=%h c%0d", a, i), {30'd0, resp_valid}, 32'd0);
    end
    nxt(); smp();
    chk($sformatf("rd_valid a=%h", a), {30'd0, resp_valid}, 32'd1 << p);
    chk($sformatf("rd_data a=%h", a), resp_data, exp);
    req_valid[p] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int got, wl0;
    int aoff [7] = '{0, 1, 1, 1, 1, 2, 3};
    logic [31:0] wexp [4] = '{32'hEF, 32'hBE, 32'hAD, 32'hDE};
    logic [8:1] wr_tab;
    wr_tab = 8'b0111_0001;

    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
    ram[12'h200] = 8'h80; ram[12'h1FF] = 8'hFE; ram[12'hFFF] = 8'h34; ram[12'h000] = 8'h12;

    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; io_buffer_full = 1'b0;
    req_valid = '0; req_write = '0; req_signed = '0; req_size = '0;
    req_addr = '0; req_wdata = '0;

    smp();
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    nxt(); rst_in = 1'b0; smp();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Both ports request continuously: grants alternate 0,1,0,1.
    nxt();
    set_req(0, 1'b0, 2'b00, 1'b0, 32'h100, 32'd0);
    set_req(1, 1'b0, 2'b00, 1'b0, 32'h101, 32'd0);
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      smp();
      if (resp_valid != 2'b00) begin
        chk($sformatf("rr_grant%0d", got), {30'd0, resp_valid}, (got % 2 == 0) ? 32'd1 : 32'd2);
        chk($sformatf("rr_data%0d", got), resp_data, (got % 2 == 0) ? 32'h11 : 32'h22);
        got++;
        if (got == 4) req_valid = '0;
      end
      if (got < 4) nxt();
    end
    chk("rr_count", got, 32'd4);

    do_rd(1, 2'b10, 1'b0, 32'h100, 6, 32'h44332211);
    do_rd(0, 2'b00, 1'b1, 32'h200, 3, 32'hFFFFFF80);
    ram[12'h200] = 8'hCA;
    do_rd(1, 2'b01, 1'b0, 32'h1FF, 4, 32'h0000CAFE);
    do_rd(0, 2'b01, 1'b1, 32'h1FF, 4, 32'hFFFFCAFE);
    do_rd(1, 2'b01, 1'b0, 32'hFFFFFFFF, 4, 32'h00001234);
    do_rd(0, 2'b11, 1'b0, 32'h100, 6, 32'h44332211);

    // I/O store with the UART full for three cycles on byte 1.
    nxt(); set_req(1, 1'b1, 2'b10, 1'b0, 32'h30000, 32'hDEADBEEF); wl0 = wlog.size(); smp();
    for (int i = 1; i <= 8; i++) begin
      nxt(); io_buffer_full = (i >= 2 && i <= 4); smp();
      chk($sformatf("io_wr c%0d", i), {31'd0, mem_wr}, {31'd0, wr_tab[i]});
      if (i <= 7) begin
        chk($sformatf("io_addr c%0d", i), mem_a, 32'h30000 + 32'(aoff[i-1]));
        chk($sformatf("io_dout c%0d", i), {24'd0, mem_dout}, wexp[aoff[i-1]]);
      end
      chk($sformatf("io_resp c%0d", i), {30'd0, resp_valid}, (i == 8) ? 32'd2 : 32'd0);
    end
    req_valid[1] = 1'b0; io_buffer_full = 1'b0;
    chk("io_wlog_len", wlog.size() - wl0, 32'd4);
    for (int j = 0; j < 4; j++) begin
      if (wlog.size() > wl0 + j) begin
        chk($sformatf("io_wlog_a%0d", j), wlog[wl0+j][39:8], 32'h30000 + 32'(j));
        chk($sformatf("io_wlog_d%0d", j), {24'd0, wlog[wl0+j][7:0]}, wexp[j]);
      end
    end

    // Flush aborts masked port-0 load; concurrent port-1 store still completes.
    nxt();
    set_req(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    set_req(1, 1'b1, 2'b10, 1'b0, 32'h400, 32'h12345678);
    smp();
    nxt(); smp(); chk("fl_grant0_addr", mem_a, 32'h100);
    nxt(); smp(); chk("fl_resp_t2", {30'd0, resp_valid}, 32'd0);
    nxt(); flush_in = 1'b1; req_valid[0] = 1'b0; smp();
    chk("fl_busy_t3", {31'd0, busy}, 32'd1);
    chk("fl_resp_t3", {30'd0, resp_valid}, 32'd0);
    nxt(); flush_in = 1'b0; smp();
    chk("fl_busy_t4", {31'd0, busy}, 32'd0);
    chk("fl_resp_t4", {30'd0, resp_valid}, 32'd0);
    for (int i = 5; i <= 9; i++) begin
      nxt(); smp();
      if (i < 9) begin
        chk($sformatf("fl_sw_wr c%0d", i), {31'd0, mem_wr}, 32'd1);
        chk($sformatf("fl_sw_addr c%0d", i), mem_a, 32'h400 + 32'(i - 5));
      end
      chk($sformatf("fl_sw_resp c%0d", i), {30'd0, resp_valid}, (i == 9) ? 32'd2 : 32'd0);
    end
    req_valid[1] = 1'b0;

    // Flush in IDLE skips masked port 0; flush in DONE kills only the masked read.
    nxt(); flush_in = 1'b1;
    set_req(0, 1'b0, 2'b00, 1'b0, 32'h100, 32'd0);
    set_req(1, 1'b0, 2'b00, 1'b0, 32'h101, 32'd0);
    smp();
    nxt(); flush_in = 1'b0; smp(); chk("fi_grant1_addr", mem_a, 32'h101);
    nxt(); smp();
    nxt(); smp();
    chk("fi_resp", {30'd0, resp_valid}, 32'd2);
    chk("fi_data", resp_data, 32'h22);
    req_valid[1] = 1'b0;
    nxt(); smp();
    nxt(); smp(); chk("fd_grant0_addr", mem_a, 32'h100);
    nxt(); smp();
    nxt(); flush_in = 1'b1; req_valid[0] = 1'b0; smp();
    chk("fd_busy_done", {31'd0, busy}, 32'd1);
    chk("fd_masked_resp", {30'd0, resp_valid}, 32'd0);
    nxt(); flush_in = 1'b0; set_req(1, 1'b0, 2'b00, 1'b0, 32'h101, 32'd0); smp();
    chk("fd_busy_after", {31'd0, busy}, 32'd0);
    nxt(); smp();
    nxt(); smp();
    nxt(); flush_in = 1'b1; smp();
    chk("fd_unmasked_resp", {30'd0, resp_valid}, 32'd2);
    chk("fd_unmasked_data", resp_data, 32'h22);
    req_valid[1] = 1'b0;
    nxt(); flush_in = 1'b0;

    // Reset in the middle of a store at byte 2.
    set_req(0, 1'b1, 2'b10, 1'b0, 32'h500, 32'hA1B2C3D4); wl0 = wlog.size(); smp();
    nxt(); smp(); chk("rs_dout_k0", {24'd0, mem_dout}, 32'hD4);
    nxt(); smp(); chk("rs_dout_k1", {24'd0, mem_dout}, 32'hC3);
    nxt();
    chk("rs_wr_k2", {31'd0, mem_wr}, 32'd1);
    rst_in = 1'b1; req_valid = '0; smp();
    chk("rs_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rs_mem_a", mem_a, 32'd0);
    chk("rs_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rs_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("rs_resp_data", resp_data, 32'd0);
    chk("rs_busy", {31'd0, busy}, 32'd0);
    nxt(); rst_in = 1'b0;
    set_req(0, 1'b0, 2'b00, 1'b0, 32'h100, 32'd0);
    set_req(1, 1'b0, 2'b00, 1'b0, 32'h101, 32'd0);
    smp();
    nxt(); smp(); chk("rs_first_grant_addr", mem_a, 32'h100);
    nxt(); smp();
    nxt(); smp();
    chk("rs_first_resp", {30'd0, resp_valid}, 32'd1);
    chk("rs_first_data", resp_data, 32'h11);
    req_valid = '0;
    chk("rs_wlog_len", wlog.size() - wl0, 32'd2);
    if (wlog.size() >= wl0 + 2) begin
      chk("rs_wlog0", {wlog[wl0][39:8] - 32'h500, 24'd0} | {24'd0, wlog[wl0][7:0]}, 32'hD4);
      chk("rs_wlog1", wlog[wl0+1][39:8], 32'h501);
    end
    nxt(); smp();
    chk("end_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
